// File: rtl/aes_key_sched_pkg.sv
// aes_pkg: shared key-schedule helpers and state type.
// Contents: legal KEY_BITS check, NK/NR/NW derivation, GF(2^8) xtime,
// IDLE/GEN state enum.
package aes_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  function automatic logic key_bits_ok(input int unsigned kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

  function automatic int unsigned calc_nk(input int unsigned kb);
    return kb / 32;
  endfunction

  function automatic int unsigned calc_nr(input int unsigned kb);
    return calc_nk(kb) + 6;
  endfunction

  function automatic int unsigned calc_nw(input int unsigned kb);
    return 4 * (calc_nr(kb) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: key load handshake, status and round-key read port.
// master: key_in/key_valid/rd_round (+rd_rev) out; status and rd_key in.
// slave : mirror of master.
// AES_KEY_SCHED_REV_EN adds rd_rev (reverse round order on reads).
interface aes_key_sched_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic                busy;
  logic                done;
  logic                keys_valid;
  logic [3:0]          rd_round;
  logic [127:0]        rd_key;
`ifdef AES_KEY_SCHED_REV_EN
  logic                rd_rev;

  modport master (output key_in, key_valid, rd_round, rd_rev,
                  input  key_ready, busy, done, keys_valid, rd_key);
  modport slave  (input  key_in, key_valid, rd_round, rd_rev,
                  output key_ready, busy, done, keys_valid, rd_key);
`else
  modport master (output key_in, key_valid, rd_round,
                  input  key_ready, busy, done, keys_valid, rd_key);
  modport slave  (input  key_in, key_valid, rd_round,
                  output key_ready, busy, done, keys_valid, rd_key);
`endif
endinterface

// File: rtl/aes_key_sched_sub_word.sv
// aes_sub_word: SubWord, one S-box per byte of a 32-bit schedule word.
// Ports: i_word (word in), o_word (substituted word out).
module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sbox u_sbox (
      .i_a (i_word[8*b +: 8]),
      .o_s (o_word[8*b +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box, computed as GF(2^8) inverse plus affine map.
// Ports: i_a (byte in), o_s (substituted byte out). Purely combinational.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 for a != 0, and 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  assign w_inv = gf_inv(i_a);
  assign o_s   = w_inv ^ {w_inv[6:0], w_inv[7]}   ^ {w_inv[5:0], w_inv[7:6]}
                       ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: sequential AES-128/192/256 key expansion, one word per cycle,
// with a registered 128-bit round-key read port.
// Ports: clk, rst_n (async, active low), bus (aes_key_sched_if.slave).
// AES_KEY_SCHED_REV_EN: rd_rev selects round NR-rd_round on reads.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_sched_if.slave        bus
);

  localparam int unsigned NK = calc_nk(KEY_BITS);
  localparam int unsigned NR = calc_nr(KEY_BITS);
  localparam int unsigned NW = calc_nw(KEY_BITS);
  localparam int unsigned IW = 6;

  if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
  end

  state_e        r_state;
  state_e        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [2:0]    r_pos;          // i mod NK
  logic [7:0]    r_rcon;
  logic [31:0]   r_win [NK];     // w[i-NK] .. w[i-1]
  logic [31:0]   r_mem [NW];
  logic          r_done;
  logic          r_keys_valid;
  logic [127:0]  r_rd_key;

  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic          w_rd_ok;
  logic [3:0]    w_round;
  logic [IW-1:0] w_base;
  logic [127:0]  w_rd_data;

  assign w_accept = bus.key_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == IW'(NW - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_GEN;
      ST_GEN:  if (w_last)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Next schedule word from the sliding window.
  always_comb begin
    w_sub_in = r_win[NK-1];
    w_temp   = r_win[NK-1];
    if (r_pos == 3'd0) begin
      w_sub_in = {r_win[NK-1][7:0], r_win[NK-1][31:8]};
      w_temp   = w_sub_out ^ {24'd0, r_rcon};
    end else if ((NK == 8) && (r_pos == 3'd4)) begin
      w_temp   = w_sub_out;
    end
    w_new = r_win[0] ^ w_temp;
  end

  // Read address; out-of-range rounds are clamped here and zeroed at the register.
  always_comb begin
    w_rd_ok = (bus.rd_round <= 4'(NR));
`ifdef AES_KEY_SCHED_REV_EN
    w_round = bus.rd_rev ? (4'(NR) - bus.rd_round) : bus.rd_round;
`else
    w_round = bus.rd_round;
`endif
    if (!w_rd_ok) w_round = 4'd0;
    w_base    = {w_round, 2'b00};
    w_rd_data = {r_mem[w_base + IW'(3)], r_mem[w_base + IW'(2)],
                 r_mem[w_base + IW'(1)], r_mem[w_base]};
  end

  // Generation control, window, status and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_pos        <= 3'd0;
      r_rcon       <= 8'h01;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_rd_key     <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        for (int j = 0; j < NK; j++) r_win[j] <= bus.key_in[32*j +: 32];
        r_idx        <= IW'(NK);
        r_pos        <= 3'd0;
        r_rcon       <= 8'h01;
        r_keys_valid <= 1'b0;
      end else if (r_state == ST_GEN) begin
        for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
        r_win[NK-1] <= w_new;
        r_idx       <= r_idx + 1'b1;
        r_pos       <= (r_pos == 3'(NK - 1)) ? 3'd0 : r_pos + 3'd1;
        if (r_pos == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last) begin
          r_done       <= 1'b1;
          r_keys_valid <= 1'b1;
        end
      end
      r_rd_key <= (r_keys_valid && !w_accept && w_rd_ok) ? w_rd_data : '0;
    end
  end

  // Schedule storage; contents are only visible while keys_valid is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NK; j++) r_mem[j] <= bus.key_in[32*j +: 32];
    end else if (r_state == ST_GEN) begin
      r_mem[r_idx] <= w_new;
    end
  end

  assign bus.key_ready  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state == ST_GEN);
  assign bus.done       = r_done;
  assign bus.keys_valid = r_keys_valid;
  assign bus.rd_key     = r_rd_key;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: directed FIPS-197 A.1/A.2/A.3 vectors on three instances,
// plus handshake, re-key, out-of-range read and mid-generation reset cases.
module tb_aes_key_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched_if #(.KEY_BITS(128)) bus_a ();
  aes_key_sched_if #(.KEY_BITS(192)) bus_b ();
  aes_key_sched_if #(.KEY_BITS(256)) bus_c ();

  aes_key_sched #(.KEY_BITS(128)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  aes_key_sched #(.KEY_BITS(192)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  aes_key_sched #(.KEY_BITS(256)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // FIPS hex strings list byte 0 first (MSB side); the DUT wants byte 0 at [7:0].
  function automatic logic [255:0] rev_bytes(input logic [255:0] x, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = x[8*(n-1-i) +: 8];
    return r;
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return bus_a.done;
      1:       return bus_b.done;
      default: return bus_c.done;
    endcase
  endfunction

  // Called #1 after the acceptance edge; counts edges until done is seen.
  task automatic wait_done(input int sel, output int cnt);
    cnt = 0;
    while (!done_of(sel) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic accept_a(input logic [127:0] k);
    @(negedge clk);
    bus_a.key_in    = k;
    bus_a.key_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.key_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] r, input logic [127:0] exp);
    @(negedge clk);
    bus_a.rd_round = r;
    @(posedge clk); #1;
    check(tag, bus_a.rd_key, exp);
  endtask

  logic [127:0] key_a, a_r1, a_r10, b_r12, c_r1, c_r14;
  logic [191:0] key_b;
  logic [255:0] key_c;
  int           cnt, lows, accepts;

  initial begin
    key_a = 128'(rev_bytes(256'h2b7e151628aed2a6abf7158809cf4f3c, 16));
    a_r1  = 128'(rev_bytes(256'ha0fafe1788542cb123a339392a6c7605, 16));
    a_r10 = 128'(rev_bytes(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16));
    key_b = 192'(rev_bytes(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24));
    b_r12 = 128'(rev_bytes(256'he98ba06f448c773c8ecc720401002202, 16));
    key_c = rev_bytes(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
    c_r1  = 128'(rev_bytes(256'h1f352c073b6108d72d9810a30914dff4, 16));
    c_r14 = 128'(rev_bytes(256'hfe4890d1e6188d0b046df344706c631e, 16));

    bus_a.key_in = '0; bus_a.key_valid = 1'b0; bus_a.rd_round = 4'd0;
    bus_b.key_in = '0; bus_b.key_valid = 1'b0; bus_b.rd_round = 4'd0;
    bus_c.key_in = '0; bus_c.key_valid = 1'b0; bus_c.rd_round = 4'd0;
`ifdef AES_KEY_SCHED_REV_EN
    bus_a.rd_rev = 1'b0; bus_b.rd_rev = 1'b0; bus_c.rd_rev = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_key_ready",  bus_a.key_ready,  1'b1);
    check("rst_busy",       bus_a.busy,       1'b0);
    check("rst_done",       bus_a.done,       1'b0);
    check("rst_keys_valid", bus_a.keys_valid, 1'b0);
    check("rst_rd_key",     bus_a.rd_key,     128'd0);
    rst_n = 1'b1;

    // AES-128 A.1
    accept_a(key_a);
    check("a128_busy_after_accept", bus_a.busy, 1'b1);
    check("a128_ready_low",         bus_a.key_ready, 1'b0);
    wait_done(0, cnt);
    check("a128_latency",   32'(cnt), 32'd40);
    check("a128_keys_valid", bus_a.keys_valid, 1'b1);
    check("a128_ready_done", bus_a.key_ready, 1'b1);
    rd_a("a128_round0",  4'd0,  key_a);
    rd_a("a128_round1",  4'd1,  a_r1);
    rd_a("a128_round10", 4'd10, a_r10);
    rd_a("a128_round11", 4'd11, 128'd0);
    rd_a("a128_round15", 4'd15, 128'd0);
`ifdef AES_KEY_SCHED_REV_EN
    bus_a.rd_rev = 1'b1;
    rd_a("a128_rev_round0",  4'd0,  a_r10);
    rd_a("a128_rev_round10", 4'd10, key_a);
    bus_a.rd_rev = 1'b0;
    rd_a("a128_fwd_round10", 4'd10, a_r10);
`endif

    // AES-192 A.2
    @(negedge clk);
    bus_b.key_in = key_b; bus_b.key_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.key_valid = 1'b0;
    wait_done(1, cnt);
    check("a192_latency", 32'(cnt), 32'd46);
    @(negedge clk); bus_b.rd_round = 4'd12;
    @(posedge clk); #1;
    check("a192_round12", bus_b.rd_key, b_r12);

    // AES-256 A.3
    @(negedge clk);
    bus_c.key_in = key_c; bus_c.key_valid = 1'b1;
    @(posedge clk); #1;
    bus_c.key_valid = 1'b0;
    wait_done(2, cnt);
    check("a256_latency", 32'(cnt), 32'd52);
    @(negedge clk); bus_c.rd_round = 4'd14;
    @(posedge clk); #1;
    check("a256_round14", bus_c.rd_key, c_r14);
    @(negedge clk); bus_c.rd_round = 4'd1;
    @(posedge clk); #1;
    check("a256_round1", bus_c.rd_key, c_r1);

    // key_valid held high: one acceptance, then 40 cycles of key_ready low
    lows = 0; accepts = 0;
    @(negedge clk);
    bus_a.key_in = key_a; bus_a.key_valid = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k != 0) @(negedge clk);
      if (bus_a.key_ready) accepts++;
      else                 lows++;
    end
    check("held_accepts",   32'(accepts), 32'd1);
    check("held_ready_low", 32'(lows),    32'd40);
    @(negedge clk);
    check("rekey_done_cycle",  bus_a.done,       1'b1);
    check("rekey_ready_done",  bus_a.key_ready,  1'b1);
    @(posedge clk); #1;
    bus_a.key_valid = 1'b0;
    check("rekey_keys_valid_drop", bus_a.keys_valid, 1'b0);
    check("rekey_busy",            bus_a.busy,       1'b1);
    wait_done(0, cnt);
    check("rekey_latency", 32'(cnt), 32'd40);
    rd_a("rekey_round10", 4'd10, a_r10);

    // Reset 20 cycles into generation
    accept_a(key_a);
    repeat (19) @(posedge clk);
    #1;
    check("midgen_busy_before", bus_a.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midgen_rst_key_ready",  bus_a.key_ready,  1'b1);
    check("midgen_rst_busy",       bus_a.busy,       1'b0);
    check("midgen_rst_done",       bus_a.done,       1'b0);
    check("midgen_rst_keys_valid", bus_a.keys_valid, 1'b0);
    check("midgen_rst_rd_key",     bus_a.rd_key,     128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r <= 10; r++) rd_a($sformatf("midgen_round%0d_zero", r), 4'(r), 128'd0);
    accept_a(key_a);
    wait_done(0, cnt);
    check("rerun_latency", 32'(cnt), 32'd40);
    rd_a("rerun_round10", 4'd10, a_r10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
